// File: rtl/mod_control_sequencer_pkg.sv
// Shared types and constants for the control sequencer.
// Holds the instruction class codes, the FSM state encoding, the branch
// condition codes, the legal-FS limit, the system-class encodings and the
// packed instruction word layout.
package mod_ctrl_pkg;

    localparam int unsigned DATA_W  = 32;
    localparam int unsigned REG_AW  = 5;
    localparam int unsigned FS_W    = 5;
    localparam int unsigned SH_W    = 5;
    localparam int unsigned PSR_W   = 4;
    localparam int unsigned IMM15_W = 15;

    // PSR bit positions, PSR = {N,Z,C,V}
    localparam int unsigned PSR_N = 3;
    localparam int unsigned PSR_Z = 2;
    localparam int unsigned PSR_C = 1;
    localparam int unsigned PSR_V = 0;

    localparam logic [1:0] CLS_ALU_R = 2'b00;
    localparam logic [1:0] CLS_ALU_I = 2'b01;
    localparam logic [1:0] CLS_BR    = 2'b10;
    localparam logic [1:0] CLS_SYS   = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE,
        S_DECODE,
        S_EXECUTE,
        S_WRITEBACK,
        S_HALT
    } state_t;

    localparam logic [FS_W-1:0] COND_ALWAYS = 5'b00000;
    localparam logic [FS_W-1:0] COND_Z      = 5'b00001;
    localparam logic [FS_W-1:0] COND_NZ     = 5'b00010;
    localparam logic [FS_W-1:0] COND_C      = 5'b00011;
    localparam logic [FS_W-1:0] COND_NC     = 5'b00100;
    localparam logic [FS_W-1:0] COND_N      = 5'b00101;
    localparam logic [FS_W-1:0] COND_NN     = 5'b00110;
    localparam logic [FS_W-1:0] COND_V      = 5'b00111;
    localparam logic [FS_W-1:0] COND_NV     = 5'b01000;

    localparam logic [FS_W-1:0] FS_MAX_LEGAL = 5'b10011;
    localparam logic [FS_W-1:0] SYS_NOP      = 5'b00000;
    localparam logic [FS_W-1:0] SYS_HALT     = 5'b11111;

    // Instruction word; BA = low[14:10], SH = low[4:0], IMM15 = low
    typedef struct packed {
        logic [1:0]          cls;
        logic [FS_W-1:0]     fs;
        logic [REG_AW-1:0]   da;
        logic [REG_AW-1:0]   aa;
        logic [IMM15_W-1:0]  low;
    } instr_t;

    function automatic logic [DATA_W-1:0] sext_imm15(input logic [IMM15_W-1:0] v);
        return {{(DATA_W - IMM15_W){v[IMM15_W-1]}}, v};
    endfunction

endpackage

// File: rtl/mod_control_sequencer_if.sv
// Instruction handshake, flag inputs and decoded control outputs of the
// control sequencer. master = fetch / function-unit side, slave = sequencer.
interface mod_control_sequencer_if;
    import mod_ctrl_pkg::*;

    logic [DATA_W-1:0]  INSTR;
    logic               INSTR_VALID;
    logic               INSTR_READY;
    logic               Z_IN;
    logic               C_IN;
    logic               N_IN;
    logic               V_IN;
    logic [FS_W-1:0]    FS;
    logic [SH_W-1:0]    SH;
    logic [REG_AW-1:0]  AA;
    logic [REG_AW-1:0]  BA;
    logic [REG_AW-1:0]  DA;
    logic               MB;
    logic [DATA_W-1:0]  IMM;
    logic               RW;
    logic               PC_LOAD;
    logic [DATA_W-1:0]  PC_OFFSET;
    logic [PSR_W-1:0]   PSR;
    logic               ILLEGAL;
    logic               HALTED;

    modport master (
        output INSTR, INSTR_VALID, Z_IN, C_IN, N_IN, V_IN,
        input  INSTR_READY, FS, SH, AA, BA, DA, MB, IMM, RW,
               PC_LOAD, PC_OFFSET, PSR, ILLEGAL, HALTED
    );

    modport slave (
        input  INSTR, INSTR_VALID, Z_IN, C_IN, N_IN, V_IN,
        output INSTR_READY, FS, SH, AA, BA, DA, MB, IMM, RW,
               PC_LOAD, PC_OFFSET, PSR, ILLEGAL, HALTED
    );

endinterface

// File: rtl/mod_control_sequencer_cond_eval.sv
// Branch condition evaluator (combinational).
// Ports: cond - branch condition code, psr - {N,Z,C,V}, taken - condition holds.
module mod_cond_eval
    import mod_ctrl_pkg::*;
(
    input  logic [FS_W-1:0]  cond,
    input  logic [PSR_W-1:0] psr,
    output logic             taken
);

    always_comb begin
        taken = 1'b0;
        case (cond)
            COND_ALWAYS: taken = 1'b1;
            COND_Z:      taken = psr[PSR_Z];
            COND_NZ:     taken = ~psr[PSR_Z];
            COND_C:      taken = psr[PSR_C];
            COND_NC:     taken = ~psr[PSR_C];
            COND_N:      taken = psr[PSR_N];
            COND_NN:     taken = ~psr[PSR_N];
            COND_V:      taken = psr[PSR_V];
            COND_NV:     taken = ~psr[PSR_V];
            default:     taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/mod_control_sequencer.sv
// Multi-cycle control sequencer: accepts one instruction per 4 cycles,
// decodes it into function-unit / register-file controls, captures flags
// into PSR and resolves conditional branches.
// Ports: CLK, RESET_N (synchronous, active low), bus (slave side of
// mod_control_sequencer_if: instruction handshake, flags, controls, status).
module mod_control_sequencer
    import mod_ctrl_pkg::*;
(
    input  logic                    CLK,
    input  logic                    RESET_N,
    mod_control_sequencer_if.slave  bus
);

    state_t              state_q, state_d;
    instr_t              ir_q, ir_nx;
    logic [PSR_W-1:0]    psr_q, psr_d;

    logic                ready_q, ready_d;
    logic [FS_W-1:0]     fs_q, fs_d;
    logic [SH_W-1:0]     sh_q, sh_d;
    logic [REG_AW-1:0]   aa_q, aa_d;
    logic [REG_AW-1:0]   ba_q, ba_d;
    logic [REG_AW-1:0]   da_q, da_d;
    logic                mb_q, mb_d;
    logic [DATA_W-1:0]   imm_q, imm_d;
    logic                rw_q, rw_d;
    logic                pc_load_q, pc_load_d;
    logic [DATA_W-1:0]   pc_offset_q, pc_offset_d;
    logic                illegal_q, illegal_d;
    logic                halted_q, halted_d;

    logic handshake;
    logic is_alu, alu_legal, is_br, is_sys, is_halt, sys_illegal;
    logic br_taken;

    // IR as it will be after this edge; outputs are registered, so they are
    // decoded from the incoming word on the IDLE->DECODE edge.
    assign handshake = (state_q == S_IDLE) && bus.INSTR_VALID;
    assign ir_nx     = handshake ? instr_t'(bus.INSTR) : ir_q;

    assign is_alu      = ~ir_nx.cls[1];
    assign alu_legal   = is_alu && (ir_nx.fs <= FS_MAX_LEGAL);
    assign is_br       = (ir_nx.cls == CLS_BR);
    assign is_sys      = (ir_nx.cls == CLS_SYS);
    assign is_halt     = is_sys && (ir_nx.fs == SYS_HALT);
    assign sys_illegal = is_sys && (ir_nx.fs != SYS_NOP) && (ir_nx.fs != SYS_HALT);

    // PSR is stable across a branch's own execution, so evaluating it on the
    // EXECUTE->WRITEBACK edge equals evaluating it in WRITEBACK.
    mod_cond_eval u_cond_eval (
        .cond  (ir_nx.fs),
        .psr   (psr_q),
        .taken (br_taken)
    );

    // Next state and next registered outputs
    always_comb begin
        state_d     = state_q;
        psr_d       = psr_q;
        ready_d     = 1'b0;
        fs_d        = '0;
        sh_d        = '0;
        aa_d        = '0;
        ba_d        = '0;
        da_d        = '0;
        mb_d        = 1'b0;
        imm_d       = '0;
        rw_d        = 1'b0;
        pc_load_d   = 1'b0;
        pc_offset_d = '0;
        illegal_d   = 1'b0;
        halted_d    = 1'b0;

        case (state_q)
            S_IDLE:      if (handshake) state_d = S_DECODE;
            S_DECODE:    state_d = S_EXECUTE;
            S_EXECUTE: begin
                state_d = S_WRITEBACK;
                if (alu_legal) psr_d = {bus.N_IN, bus.Z_IN, bus.C_IN, bus.V_IN};
            end
            S_WRITEBACK: state_d = is_halt ? S_HALT : S_IDLE;
            S_HALT:      state_d = S_HALT;
            default:     state_d = S_IDLE;
        endcase

        ready_d  = (state_d == S_IDLE);
        halted_d = (state_d == S_HALT);

        if (state_d inside {S_DECODE, S_EXECUTE, S_WRITEBACK}) begin
            fs_d  = is_alu ? ir_nx.fs : '0;
            mb_d  = (ir_nx.cls == CLS_ALU_I);
            sh_d  = ir_nx.low[SH_W-1:0];
            aa_d  = ir_nx.aa;
            ba_d  = ir_nx.low[IMM15_W-1 -: REG_AW];
            da_d  = ir_nx.da;
            imm_d = sext_imm15(ir_nx.low);
        end

        if (state_d == S_WRITEBACK) begin
            rw_d        = alu_legal;
            illegal_d   = (is_alu && !alu_legal) || sys_illegal;
            pc_load_d   = is_br && br_taken;
            pc_offset_d = (is_br && br_taken) ? sext_imm15(ir_nx.low) : '0;
        end
    end

    // State register
    always_ff @(posedge CLK) begin
        if (!RESET_N) state_q <= S_IDLE;
        else          state_q <= state_d;
    end

    // IR, PSR and output registers
    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            ir_q        <= '0;
            psr_q       <= '0;
            ready_q     <= 1'b1;
            fs_q        <= '0;
            sh_q        <= '0;
            aa_q        <= '0;
            ba_q        <= '0;
            da_q        <= '0;
            mb_q        <= 1'b0;
            imm_q       <= '0;
            rw_q        <= 1'b0;
            pc_load_q   <= 1'b0;
            pc_offset_q <= '0;
            illegal_q   <= 1'b0;
            halted_q    <= 1'b0;
        end else begin
            ir_q        <= ir_nx;
            psr_q       <= psr_d;
            ready_q     <= ready_d;
            fs_q        <= fs_d;
            sh_q        <= sh_d;
            aa_q        <= aa_d;
            ba_q        <= ba_d;
            da_q        <= da_d;
            mb_q        <= mb_d;
            imm_q       <= imm_d;
            rw_q        <= rw_d;
            pc_load_q   <= pc_load_d;
            pc_offset_q <= pc_offset_d;
            illegal_q   <= illegal_d;
            halted_q    <= halted_d;
        end
    end

    assign bus.INSTR_READY = ready_q;
    assign bus.FS          = fs_q;
    assign bus.SH          = sh_q;
    assign bus.AA          = aa_q;
    assign bus.BA          = ba_q;
    assign bus.DA          = da_q;
    assign bus.MB          = mb_q;
    assign bus.IMM         = imm_q;
    assign bus.RW          = rw_q;
    assign bus.PC_LOAD     = pc_load_q;
    assign bus.PC_OFFSET   = pc_offset_q;
    assign bus.PSR         = psr_q;
    assign bus.ILLEGAL     = illegal_q;
    assign bus.HALTED      = halted_q;

endmodule

// File: tb/tb_mod_control_sequencer.sv
// Self-checking bench for mod_control_sequencer: a reference model pushes
// expected writeback results into a queue at issue; they are popped and
// compared when the instruction reaches WRITEBACK.
module tb_mod_control_sequencer;
    import mod_ctrl_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mod_control_sequencer_if bus();

    mod_control_sequencer dut (
        .CLK     (clk),
        .RESET_N (rst_n),
        .bus     (bus)
    );

    typedef struct packed {
        logic        rw;
        logic [4:0]  da;
        logic        pc_load;
        logic [31:0] pc_off;
        logic        illegal;
        logic [3:0]  psr;
        logic        halt;
    } exp_t;

    exp_t       exp_q[$];
    int         errors = 0;
    int         checks = 0;
    logic [3:0] psr_m = 4'b0000;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mk(input logic [1:0] c, input logic [4:0] f,
                                       input logic [4:0] da, input logic [4:0] aa,
                                       input logic [14:0] low);
        return {c, f, da, aa, low};
    endfunction

    // Reference model of one instruction's writeback effect; flags = {N,Z,C,V}
    function automatic exp_t model(input logic [31:0] ins, input logic [3:0] flags,
                                   input logic [3:0] psr);
        exp_t e;
        logic t;
        logic [4:0] f;
        e = '0;
        t = 1'b0;
        f = ins[29:25];
        e.da  = ins[24:20];
        e.psr = psr;
        case (ins[31:30])
            2'b00, 2'b01: begin
                if (f < 5'd20) begin e.rw = 1'b1; e.psr = flags; end
                else e.illegal = 1'b1;
            end
            2'b10: begin
                case (f)
                    5'd0: t = 1'b1;
                    5'd1: t = psr[2];
                    5'd2: t = !psr[2];
                    5'd3: t = psr[1];
                    5'd4: t = !psr[1];
                    5'd5: t = psr[3];
                    5'd6: t = !psr[3];
                    5'd7: t = psr[0];
                    5'd8: t = !psr[0];
                    default: t = 1'b0;
                endcase
                if (t) begin
                    e.pc_load = 1'b1;
                    e.pc_off  = {{17{ins[14]}}, ins[14:0]};
                end
            end
            default: begin
                if (f == 5'd31) e.halt = 1'b1;
                else if (f != 5'd0) e.illegal = 1'b1;
            end
        endcase
        return e;
    endfunction

    task automatic check_idle(input string tag);
        check({tag, "_ready"},  32'(bus.INSTR_READY), 1);
        check({tag, "_psr"},    32'(bus.PSR), 0);
        check({tag, "_fs"},     32'(bus.FS), 0);
        check({tag, "_sh"},     32'(bus.SH), 0);
        check({tag, "_aa"},     32'(bus.AA), 0);
        check({tag, "_ba"},     32'(bus.BA), 0);
        check({tag, "_da"},     32'(bus.DA), 0);
        check({tag, "_mb"},     32'(bus.MB), 0);
        check({tag, "_imm"},    bus.IMM, 0);
        check({tag, "_rw"},     32'(bus.RW), 0);
        check({tag, "_pcld"},   32'(bus.PC_LOAD), 0);
        check({tag, "_pcoff"},  bus.PC_OFFSET, 0);
        check({tag, "_ill"},    32'(bus.ILLEGAL), 0);
        check({tag, "_halted"}, 32'(bus.HALTED), 0);
    endtask

    // Issue one instruction at a negedge and follow it through t+1..t+4
    task automatic run_instr(input string tag, input logic [31:0] ins, input logic [3:0] flags);
        exp_t        e;
        int          w;
        logic [4:0]  exp_fs;
        logic [31:0] exp_imm;
        exp_fs  = ins[31] ? 5'd0 : ins[29:25];
        exp_imm = {{17{ins[14]}}, ins[14:0]};
        w = 0;
        while (!bus.INSTR_READY && w < 8) begin @(negedge clk); w++; end
        check({tag, "_wait_ready"}, 32'(bus.INSTR_READY), 1);
        bus.INSTR       = ins;
        bus.INSTR_VALID = 1'b1;
        {bus.N_IN, bus.Z_IN, bus.C_IN, bus.V_IN} = flags;
        exp_q.push_back(model(ins, flags, psr_m));

        @(negedge clk);  // DECODE
        bus.INSTR_VALID = 1'b0;
        bus.INSTR       = ~ins;
        check({tag, "_dec_ready"}, 32'(bus.INSTR_READY), 0);
        check({tag, "_dec_fs"},    32'(bus.FS), 32'(exp_fs));
        check({tag, "_dec_aa"},    32'(bus.AA), 32'(ins[19:15]));
        check({tag, "_dec_ba"},    32'(bus.BA), 32'(ins[14:10]));
        check({tag, "_dec_da"},    32'(bus.DA), 32'(ins[24:20]));
        check({tag, "_dec_sh"},    32'(bus.SH), 32'(ins[4:0]));
        check({tag, "_dec_mb"},    32'(bus.MB), 32'(ins[31:30] == 2'b01));
        check({tag, "_dec_imm"},   bus.IMM, exp_imm);
        check({tag, "_dec_rw"},    32'(bus.RW), 0);

        @(negedge clk);  // EXECUTE
        check({tag, "_ex_fs"},   32'(bus.FS), 32'(exp_fs));
        check({tag, "_ex_rw"},   32'(bus.RW), 0);
        check({tag, "_ex_pcld"}, 32'(bus.PC_LOAD), 0);

        @(negedge clk);  // WRITEBACK
        e = exp_q.pop_front();
        check({tag, "_wb_fs"},    32'(bus.FS), 32'(exp_fs));
        check({tag, "_wb_da"},    32'(bus.DA), 32'(e.da));
        check({tag, "_wb_rw"},    32'(bus.RW), 32'(e.rw));
        check({tag, "_wb_pcld"},  32'(bus.PC_LOAD), 32'(e.pc_load));
        check({tag, "_wb_pcoff"}, bus.PC_OFFSET, e.pc_off);
        check({tag, "_wb_ill"},   32'(bus.ILLEGAL), 32'(e.illegal));

        @(negedge clk);  // t+4
        check({tag, "_post_psr"},    32'(bus.PSR), 32'(e.psr));
        check({tag, "_post_ready"},  32'(bus.INSTR_READY), 32'(!e.halt));
        check({tag, "_post_halted"}, 32'(bus.HALTED), 32'(e.halt));
        check({tag, "_post_rw"},     32'(bus.RW), 0);
        check({tag, "_post_pcld"},   32'(bus.PC_LOAD), 0);
        check({tag, "_post_fs"},     32'(bus.FS), 0);
        psr_m = e.psr;
    endtask

    task automatic do_reset(input string tag);
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        psr_m = 4'b0000;
        check_idle(tag);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    initial begin
        bus.INSTR       = '0;
        bus.INSTR_VALID = 1'b0;
        bus.Z_IN = 1'b0; bus.C_IN = 1'b0; bus.N_IN = 1'b0; bus.V_IN = 1'b0;

        do_reset("reset");

        run_instr("alu_rr",     mk(2'b00, 5'b00010, 5'd3, 5'd1, {5'd2, 10'd0}), 4'b1010);
        run_instr("alu_imm",    mk(2'b01, 5'b00101, 5'd7, 5'd4, 15'h4123), 4'b0100);
        run_instr("br_z",       mk(2'b10, 5'b00001, 5'd0, 5'd0, 15'h7FFE), 4'b0000);
        run_instr("br_nz",      mk(2'b10, 5'b00010, 5'd0, 5'd0, 15'h7FFE), 4'b0000);
        run_instr("br_n",       mk(2'b10, 5'b00101, 5'd1, 5'd2, 15'h0123), 4'b1111);
        run_instr("br_always",  mk(2'b10, 5'b00000, 5'd0, 5'd0, 15'h0040), 4'b0000);
        run_instr("br_never",   mk(2'b10, 5'b01001, 5'd0, 5'd0, 15'h0040), 4'b0000);
        run_instr("alu_illfs",  mk(2'b00, 5'b10100, 5'd9, 5'd3, 15'h0011), 4'b1111);
        run_instr("alu_maxfs",  mk(2'b01, 5'b10011, 5'd31, 5'd30, 15'h7FFF), 4'b0001);
        run_instr("br_v",       mk(2'b10, 5'b00111, 5'd0, 5'd0, 15'h4000), 4'b0000);
        run_instr("br_nv",      mk(2'b10, 5'b01000, 5'd0, 5'd0, 15'h4000), 4'b0000);
        run_instr("br_c",       mk(2'b10, 5'b00011, 5'd0, 5'd0, 15'h0100), 4'b0000);
        run_instr("br_nc",      mk(2'b10, 5'b00100, 5'd0, 5'd0, 15'h0100), 4'b0000);
        run_instr("sys_nop",    mk(2'b11, 5'b00000, 5'd5, 5'd6, 15'h1234), 4'b1111);
        run_instr("sys_ill",    mk(2'b11, 5'b00101, 5'd5, 5'd6, 15'h1234), 4'b1111);
        run_instr("alu_da0",    mk(2'b00, 5'b00001, 5'd0, 5'd8, 15'h2001), 4'b1000);
        run_instr("alu_ill31",  mk(2'b01, 5'b11111, 5'd4, 5'd4, 15'h0004), 4'b0110);

        // Reset while an ALU instruction is in EXECUTE
        bus.INSTR       = mk(2'b00, 5'b00011, 5'd5, 5'd2, 15'h0C00);
        bus.INSTR_VALID = 1'b1;
        {bus.N_IN, bus.Z_IN, bus.C_IN, bus.V_IN} = 4'b1111;
        @(negedge clk);
        bus.INSTR_VALID = 1'b0;
        check("rstex_dec_ready", 32'(bus.INSTR_READY), 0);
        @(negedge clk);
        check("rstex_ex_fs", 32'(bus.FS), 3);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        psr_m = 4'b0000;
        check_idle("rstex");
        repeat (3) begin
            @(negedge clk);
            check("rstex_after_rw",    32'(bus.RW), 0);
            check("rstex_after_ready", 32'(bus.INSTR_READY), 1);
            check("rstex_after_psr",   32'(bus.PSR), 0);
        end

        run_instr("br_nz_after_rst", mk(2'b10, 5'b00010, 5'd0, 5'd0, 15'h0010), 4'b0100);

        // HALT is sticky and refuses further instructions
        run_instr("halt", mk(2'b11, 5'b11111, 5'd0, 5'd0, 15'h0000), 4'b0000);
        bus.INSTR       = mk(2'b00, 5'b00001, 5'd2, 5'd3, 15'h0000);
        bus.INSTR_VALID = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("halt_ready",  32'(bus.INSTR_READY), 0);
            check("halt_halted", 32'(bus.HALTED), 1);
            check("halt_rw",     32'(bus.RW), 0);
        end
        bus.INSTR_VALID = 1'b0;

        do_reset("halt_reset");
        run_instr("alu_after_halt", mk(2'b00, 5'b00100, 5'd6, 5'd7, {5'd8, 10'd3}), 4'b0011);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
